tone_synth: RTL and testbench

Audio back-end stage fed directly by the song ROMs (the `Music*` beat-to-tone lookups). Takes the 32-bit tone frequency (Hz) selected for the current beat and turns it into a square wave: a 1-bit buzzer output and a signed 16-bit sample scaled by volume. The per-tone half-period is computed by an iterative divider, so there is no combinational divide. A tone change takes effect phase-continuously.

---
 rtl/audio_pkg.sv | 23 ++
 rtl/seq_div32.sv | 73 +++++++
 rtl/tone_synth.sv | 162 ++++++++++++++++
 tb/tb_tone_synth.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared constants, types and helpers for the tone synthesiser.
//   CLK_HZ      default system clock frequency, Hz
//   SILENCE_HZ  tones at or above this frequency (or zero) are treated as silence
//   AMP_SHIFT   left shift applied to the 3-bit volume to form the amplitude
//   div_state_t divider control FSM states
package audio_pkg;

  localparam int unsigned CLK_HZ     = 100_000_000;
  localparam int unsigned SILENCE_HZ = 20000;
  localparam int unsigned AMP_SHIFT  = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    LOAD = 2'd2
  } div_state_t;

  // A tone is silent when it is zero or at/above the audible cut-off.
  function automatic logic is_silent(input logic [31:0] tone_hz, input logic [31:0] limit_hz);
    return (tone_hz == 32'd0) || (tone_hz >= limit_hz);
  endfunction

endpackage

// File: rtl/seq_div32.sv
// seq_div32: 32-bit unsigned restoring divider, one quotient bit per cycle.
//   clk, rst_n  clock and asynchronous active-low reset
//   start       pulse: latch dividend/divisor and begin a 32-cycle division
//   dividend    numerator, sampled on start
//   divisor     denominator, sampled on start (must be non-zero)
//   quotient    floor(dividend / divisor), valid from the cycle after done
//   done        single-cycle pulse marking the 32nd (final) iteration
module seq_div32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic        done
);

  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        run_q, run_d;
  logic [32:0] rem_shift;

  always_comb begin
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    run_d     = run_q;
    // quo_q doubles as the dividend shift register: its MSB feeds the remainder.
    rem_shift = {rem_q, quo_q[31]};
    if (start) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      if (rem_shift >= {1'b0, dvs_q}) begin
        rem_d = 32'(rem_shift - {1'b0, dvs_q});
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = rem_shift[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done     = run_q && (cnt_q == 5'd31);
  assign quotient = quo_q;

endmodule

// File: rtl/tone_synth.sv
// tone_synth: square-wave tone generator fed by the song ROM tone lookups.
//   clk, rst_n  clock and asynchronous active-low reset
//   tone        requested frequency in Hz (0 or >= SILENCE_HZ means silence)
//   volume      amplitude step 0..7
//   mute        gates sq and sample combinationally; internal phase keeps running
//   sq          1-bit square wave, 0 while silent or muted
//   sample      signed 16-bit sample, +amp / -amp following sq, 0 while silent or muted
//   busy        high while the half-period division is in progress
// The half-period (CLK_HZ/2)/tone is computed by seq_div32; new periods are
// adopted only at half-period boundaries so the waveform stays phase-continuous.
module tone_synth #(
  parameter int unsigned CLK_HZ     = audio_pkg::CLK_HZ,
  parameter int unsigned SILENCE_HZ = audio_pkg::SILENCE_HZ
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] tone,
  input  logic [2:0]  volume,
  input  logic        mute,
  output logic        sq,
  output logic [15:0] sample,
  output logic        busy
);

  import audio_pkg::*;

  localparam logic [31:0] Dividend = 32'(CLK_HZ / 2);
  localparam logic [31:0] SilLimit = 32'(SILENCE_HZ);

  div_state_t  state_q, state_d;
  logic [31:0] tone_q;
  logic [31:0] cur_tone_q, cur_tone_d;
  logic [31:0] div_tone_q, div_tone_d;
  logic [31:0] half_q, half_d;
  logic [31:0] pend_half_q, pend_half_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] cnt_q, cnt_d;
  logic        sq_q, sq_d;
  logic [15:0] sample_q, sample_d;
  logic [15:0] amp;

  logic        div_start;
  logic        div_done;
  logic [31:0] div_quot;

  assign div_start = (state_q == IDLE) && (tone_q != cur_tone_q) && !is_silent(tone_q, SilLimit);

  seq_div32 u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (Dividend),
    .divisor  (tone_q),
    .quotient (div_quot),
    .done     (div_done)
  );

  assign amp = 16'(volume) << AMP_SHIFT;

  always_comb begin
    state_d     = state_q;
    cur_tone_d  = cur_tone_q;
    div_tone_d  = div_tone_q;
    half_d      = half_q;
    pend_half_d = pend_half_q;
    pend_v_d    = pend_v_q;
    cnt_d       = cnt_q;
    sq_d        = sq_q;

    // Waveform counter; a pending period is only taken at a half-period boundary.
    if (half_q == 32'd0) begin
      cnt_d = '0;
      sq_d  = 1'b0;
    end else if (cnt_q == half_q - 32'd1) begin
      cnt_d = '0;
      sq_d  = ~sq_q;
      if (pend_v_q) begin
        half_d   = pend_half_q;
        pend_v_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + 32'd1;
    end

    // Divider control; its writes take priority over the boundary update above.
    unique case (state_q)
      IDLE: begin
        if (tone_q != cur_tone_q) begin
          if (is_silent(tone_q, SilLimit)) begin
            cur_tone_d = tone_q;
            half_d     = '0;
            pend_v_d   = 1'b0;
            cnt_d      = '0;
            sq_d       = 1'b0;
          end else begin
            div_tone_d = tone_q;
            state_d    = DIV;
          end
        end
      end
      DIV: begin
        if (div_done) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        cur_tone_d = div_tone_q;
        state_d    = IDLE;
        if (half_q == 32'd0) begin
          // Nothing is playing, so there is no phase to preserve.
          half_d   = div_quot;
          pend_v_d = 1'b0;
          cnt_d    = '0;
          sq_d     = 1'b0;
        end else begin
          pend_half_d = div_quot;
          pend_v_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (half_d == 32'd0) begin
      sample_d = '0;
    end else if (sq_d) begin
      sample_d = amp;
    end else begin
      sample_d = 16'd0 - amp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tone_q      <= '0;
      cur_tone_q  <= '0;
      div_tone_q  <= '0;
      half_q      <= '0;
      pend_half_q <= '0;
      pend_v_q    <= 1'b0;
      cnt_q       <= '0;
      sq_q        <= 1'b0;
      sample_q    <= '0;
    end else begin
      state_q     <= state_d;
      tone_q      <= tone;
      cur_tone_q  <= cur_tone_d;
      div_tone_q  <= div_tone_d;
      half_q      <= half_d;
      pend_half_q <= pend_half_d;
      pend_v_q    <= pend_v_d;
      cnt_q       <= cnt_d;
      sq_q        <= sq_d;
      sample_q    <= sample_d;
    end
  end

  assign sq     = sq_q & ~mute;
  assign sample = mute ? 16'd0 : sample_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_tone_synth.sv
// Scoreboard bench for tone_synth, run with CLK_HZ=100_000 so half-periods are
// short: (50000 / tone) gives 262->190, 392->127, 196->255, 294->170,
// 349->143, 330->151 cycles. The driver pushes every expected change of
// {busy, sq, sample} with the cycle it must appear on; the monitor pops one
// entry per observed change.
module tb_tone_synth;

  localparam int A = 28672;

  typedef struct {
    int cyc;
    bit busy;
    bit sq;
    int smp;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] tone;
  logic [2:0]  volume;
  logic        mute;
  logic        sq;
  logic [15:0] sample;
  logic        busy;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;
  bit  rst_chk_req = 1'b0;
  bit  rst_chk_done = 1'b0;
  bit  end_req = 1'b0;
  ev_t exp_q[$];
  logic [17:0] prev = '0;
  logic [17:0] cur;

  tone_synth #(
    .CLK_HZ     (100_000),
    .SILENCE_HZ (20000)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .tone   (tone),
    .volume (volume),
    .mute   (mute),
    .sq     (sq),
    .sample (sample),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic at_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int c, input bit b, input bit s, input int smp);
    ev_t e;
    e.cyc  = c;
    e.busy = b;
    e.sq   = s;
    e.smp  = smp;
    exp_q.push_back(e);
  endtask

  // Monitor: all comparisons and the summary live here.
  always @(negedge clk) begin
    ev_t e;
    cur = {busy, sq, sample};
    if (rst_chk_req && !rst_chk_done) begin
      rst_chk_done = 1'b1;
      checks += 3;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_busy got=%b required=0", busy);
      end
      if (sq !== 1'b0) begin
        errors++;
        $display("FAIL reset_sq got=%b required=0", sq);
      end
      if (sample !== 16'd0) begin
        errors++;
        $display("FAIL reset_sample got=%h required=0000", sample);
      end
    end
    if (mon_en && (cur !== prev)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d busy=%b sq=%b sample=%0d required=no_change",
                 cyc, busy, sq, $signed(sample));
      end else begin
        e = exp_q.pop_front();
        if ((e.cyc != cyc) || (e.busy !== busy) || (e.sq !== sq) ||
            (e.smp != int'($signed(sample)))) begin
          errors++;
          $display("FAIL event got cyc=%0d busy=%b sq=%b sample=%0d required cyc=%0d busy=%b sq=%b sample=%0d",
                   cyc, busy, sq, $signed(sample), e.cyc, e.busy, e.sq, e.smp);
        end
      end
    end
    prev = cur;
    if (end_req) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL missing_events got=%0d_pending required=0 next_cyc=%0d",
                 exp_q.size(), exp_q[0].cyc);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d required=finish_before_10000_cycles", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tone   = 32'd0;
    volume = 3'd7;
    mute   = 1'b0;
    #1 rst_n = 1'b0;
    at_cycle(3);
    rst_chk_req = 1'b1;
    at_cycle(5);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // 262 Hz from silence: busy 33 cycles, loaded directly, sq starts low.
    push(12, 1, 0, 0);
    push(45, 0, 0, -A);
    push(235, 0, 1, A);
    push(425, 0, 0, -A);
    at_cycle(10);
    tone = 32'd262;

    // 392 Hz mid-period: the 190-cycle half-period at 615 completes, then 127.
    push(477, 1, 0, -A);
    push(510, 0, 0, -A);
    push(615, 0, 1, A);
    push(742, 0, 0, -A);
    push(869, 0, 1, A);
    at_cycle(475);
    tone = 32'd392;

    // 196 Hz: switch at the 996 boundary, then 255.
    push(901, 1, 1, A);
    push(934, 0, 1, A);
    push(996, 0, 0, -A);
    push(1251, 0, 1, A);
    at_cycle(899);
    tone = 32'd196;

    // Silence: outputs clear two edges later, no division.
    push(1353, 0, 0, 0);
    at_cycle(1351);
    tone = 32'd20000;

    // Back to 262, plus mute and volume=0 while playing.
    push(1653, 1, 0, 0);
    push(1686, 0, 0, -A);
    push(1876, 0, 1, A);
    push(1896, 0, 0, 0);
    push(1946, 0, 1, A);
    push(2066, 0, 0, -A);
    push(2087, 0, 0, 0);
    push(2256, 0, 1, 0);
    push(2277, 0, 1, A);
    push(2446, 0, 0, -A);
    at_cycle(1651);
    tone = 32'd262;
    at_cycle(1896);
    mute = 1'b1;
    at_cycle(1946);
    mute = 1'b0;
    at_cycle(2086);
    volume = 3'd0;
    at_cycle(2276);
    volume = 3'd7;

    // 294, then 330 and 349 during DIV: one extra division, final 143.
    push(2468, 1, 0, -A);
    push(2501, 0, 0, -A);
    push(2502, 1, 0, -A);
    push(2535, 0, 0, -A);
    push(2636, 0, 1, A);
    push(2779, 0, 0, -A);
    push(2922, 0, 1, A);
    at_cycle(2466);
    tone = 32'd294;
    at_cycle(2471);
    tone = 32'd330;
    at_cycle(2478);
    tone = 32'd349;

    // 330 Hz, reset at DIV cycle ~10, then restart from scratch: 151.
    push(2944, 1, 1, A);
    push(2953, 0, 0, 0);
    push(2958, 1, 0, 0);
    push(2991, 0, 0, -A);
    push(3142, 0, 1, A);
    push(3293, 0, 0, -A);
    at_cycle(2942);
    tone = 32'd330;
    at_cycle(2953);
    rst_n = 1'b0;
    at_cycle(2956);
    rst_n = 1'b1;

    at_cycle(3350);
    end_req = 1'b1;
  end

endmodule
